traffic_light_multi_ctrl: RTL
=============================

# traffic_light_multi_ctrl

Parametrised successor of the single-crossing traffic light controller. It drives one car signal head and one pedestrian signal head from N_PED pedestrian request buttons. Phase durations and clock rate are parameters, and a minimum car-green time is enforced. Switching off is safe: the block always finishes a yellow or pedestrian-clear phase before it enters flashing-yellow OFF mode. The block sits between the pad-level button/switch inputs and the lamp drivers, and it exposes phase and countdown for a display driver.

## Interface
- CLK_HZ, 1_000_000: clock cycles per second. Must be even and ≥2. Simulation uses 1000.
- N_PED, 2: number of pedestrian request channels (≥1).
- CNT_W, 8: width of the seconds countdown.
- T_GREEN_MIN, 10: minimum car green, in seconds.
- T_YELLOW, 3: car yellow, in seconds.
- T_ALL_RED, 2: all-red before pedestrian green, in seconds.
- T_PED_GREEN, 10: pedestrian green, in seconds.
- T_PED_CLEAR, 3: all-red after pedestrian green, in seconds.
- T_RED_YELLOW, 1: car red+yellow, in seconds.
- All T_* values are ≥1 and < 2^CNT_W.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- switch_traffic_light_on_in  in  1  asynchronous level input; 1 = run, 0 = OFF.
- ped_request_in  in  N_PED  asynchronous button inputs, active high.
- car_red_light_out / car_yellow_light_out / car_green_light_out  out  1 each  car lamps.
- ped_red_light_out / ped_green_light_out  out  1 each  pedestrian lamps.
- pushed_out  out  N_PED  latched per-channel request indicator.
- remaining_s_out  out  CNT_W  seconds left in the current timed phase.
- phase_out  out  3  current state encoding.

## Operation
**Input conditioning**
- Every asynchronous input passes through a 2-flop synchroniser.
- A button event is a rising edge on the synchronised signal.

**Request latching**
- pushed_out[i] sets on an event on channel i, but only while the state is not OFF and not PED_GREEN.
- All pushed_out bits clear on entry to PED_GREEN and on entry to OFF.
- Events in OFF or PED_GREEN are ignored.

**States** (encoding in brackets)
- OFF[0]:
  - car_yellow flashes, starting at 1 on entry and toggling every CLK_HZ/2 cycles.
  - All other lamps are 0.
- CAR_GREEN[1]: car green, ped red.
- CAR_YELLOW[2]: car yellow, ped red.
- ALL_RED[3]: car red, ped red.
- PED_GREEN[4]: car red, ped green.
- PED_CLEAR[5]: car red, ped red.
- CAR_RED_YELLOW[6]: car red and car yellow, ped red.

**Transitions**
- OFF → PED_CLEAR when the synchronised switch is 1.
- PED_CLEAR → CAR_RED_YELLOW when its timer expires, or → OFF if the switch is 0 at that point.
- CAR_RED_YELLOW → CAR_GREEN on timer expiry.
- CAR_GREEN → CAR_YELLOW on either condition:
  - switch is 0 (no minimum-green wait), or
  - min-green has elapsed and any pushed_out bit is 1.
- CAR_GREEN is held indefinitely with no request.
- CAR_YELLOW → OFF if the switch is 0, else → ALL_RED.
- ALL_RED → PED_GREEN → PED_CLEAR, each on timer expiry.
- Switch-off during ALL_RED, PED_GREEN or CAR_RED_YELLOW never shortens a phase. It takes effect at the next decision point: end of PED_CLEAR or CAR_GREEN.

**Phase timer**
- On state entry, remaining_s_out loads the phase's T value and the prescaler restarts.
- remaining_s_out decrements every CLK_HZ cycles.
- The phase expires on the decrement from 1.
- In CAR_GREEN, remaining_s_out counts T_GREEN_MIN down to 0 and saturates; 0 means min-green has elapsed.
- In OFF, remaining_s_out is 0.

## Timing
- Moore outputs: all lamps and phase_out decode registered state and change on the same edge as the state.
- **Reset values:** state OFF, car_yellow_light_out = 1, all other lamps 0, pushed_out = 0, remaining_s_out = 0, phase_out = 0. Prescaler and flash phase are cleared.
- **Reset mid-operation:** the next edge with rst_n = 0 forces the reset values, whatever the state.
- **Input latency:** with an input first sampled at edge k:
  - pushed_out rises at edge k+2;
  - OFF → PED_CLEAR happens at edge k+2.
- **CAR_GREEN → CAR_YELLOW:**
  - if min-green has already elapsed, at edge k+3 after the button sample;
  - otherwise, on the edge on which remaining_s_out would reach 0, when a request is already latched.
- **Timed phase length:** exactly T·CLK_HZ cycles.
- **Simultaneous events:**
  - several channels in one cycle → all bits latch and are served by a single pedestrian phase;
  - an event on the PED_GREEN entry edge is dropped, because clear wins.

## Structure
- Package traffic_light_pkg holds the state enum (encodings above) and the phase-duration lookup function.
- One sub-module, tl_req_latch, instantiated N_PED times: synchroniser, edge detect and set/clear latch.
- The switch synchroniser, prescaler, timer and FSM live in the top module.

## Test plan
All scenarios use CLK_HZ = 1000, N_PED = 3, and default T_* values.
1. **Reset:** rst_n low for 3 cycles → car_yellow = 1, all else 0, phase_out = 0. Yellow toggles every 500 cycles.
2. **Switch on at edge k:**
   - phase_out = 5 at k+2, held for 3000 cycles;
   - then phase 6 for 1000 cycles;
   - then phase 1, with remaining_s_out counting 10 → 0.
3. **Early request:** 1-cycle pulse on ped_request_in[0] 2 s into green →
   - pushed_out[0] = 1 two edges later;
   - yellow exactly 10000 cycles after green entry;
   - phase 2 for 3000 cycles, phase 3 for 2000, phase 4 for 10000;
   - pushed_out clears on PED_GREEN entry.
4. **Late request:** pulse on channel 2 at 15 s of green → phase_out = 2 three edges after the first sample.
5. **Simultaneous and mid-phase requests:**
   - channels 0 and 1 pulsed in the same cycle → both latch, one pedestrian phase serves both;
   - a pulse during PED_GREEN is ignored;
   - a pulse during PED_CLEAR latches and triggers yellow exactly at min-green expiry.
6. **Switch off and mid-operation reset:**
   - switch off in CAR_GREEN → 3000 cycles of yellow, then OFF;
   - switch off in PED_GREEN → PED_GREEN and PED_CLEAR complete, then OFF with pushed_out cleared;
   - rst_n low mid-phase → reset values on the next edge.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared state encoding and phase-duration lookup for the traffic light controller
package traffic_light_pkg;

    typedef enum logic [2:0] {
        OFF            = 3'd0,
        CAR_GREEN      = 3'd1,
        CAR_YELLOW     = 3'd2,
        ALL_RED        = 3'd3,
        PED_GREEN      = 3'd4,
        PED_CLEAR      = 3'd5,
        CAR_RED_YELLOW = 3'd6
    } state_t;

    // Seconds loaded into the countdown on entry to a state; OFF has no timed phase.
    function automatic int phase_secs(state_t s, int t_green_min, int t_yellow, int t_all_red,
                                      int t_ped_green, int t_ped_clear, int t_red_yellow);
        return s == CAR_GREEN      ? t_green_min :
               s == CAR_YELLOW     ? t_yellow    :
               s == ALL_RED        ? t_all_red   :
               s == PED_GREEN      ? t_ped_green :
               s == PED_CLEAR      ? t_ped_clear :
               s == CAR_RED_YELLOW ? t_red_yellow : 0;
    endfunction

endpackage

// File: rtl/tl_req_latch.sv
// tl_req_latch: one pedestrian request channel (synchroniser, rising-edge detect, set/clear latch)
// Ports: clk, rst_n (sync, active low); req async button; set_en allows latching;
//   clr clears the latch and wins over a simultaneous set; pushed latched request.
module tl_req_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic set_en,
    input  logic clr,
    output logic pushed
);

    logic meta, sync, prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            prev   <= 1'b0;
            pushed <= 1'b0;
        end else begin
            meta   <= req;
            sync   <= meta;
            prev   <= sync;
            pushed <= clr ? 1'b0 : pushed | (set_en && sync && !prev);
        end
    end

endmodule

// File: rtl/traffic_light_multi_ctrl.sv
// traffic_light_multi_ctrl: car/pedestrian signal controller with N_PED request buttons, min-green and safe switch-off
// Ports: clk, rst_n (sync, active low); switch_traffic_light_on_in async run(1)/off(0);
//   ped_request_in[N_PED] async buttons; car_*/ped_* lamp drives; pushed_out latched requests;
//   remaining_s_out seconds left in the timed phase; phase_out current state code.
module traffic_light_multi_ctrl #(
    parameter int CLK_HZ       = 1_000_000,
    parameter int N_PED        = 2,
    parameter int CNT_W        = 8,
    parameter int T_GREEN_MIN  = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 2,
    parameter int T_PED_GREEN  = 10,
    parameter int T_PED_CLEAR  = 3,
    parameter int T_RED_YELLOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             switch_traffic_light_on_in,
    input  logic [N_PED-1:0] ped_request_in,
    output logic             car_red_light_out,
    output logic             car_yellow_light_out,
    output logic             car_green_light_out,
    output logic             ped_red_light_out,
    output logic             ped_green_light_out,
    output logic [N_PED-1:0] pushed_out,
    output logic [CNT_W-1:0] remaining_s_out,
    output logic [2:0]       phase_out
);

    import traffic_light_pkg::*;

    localparam int PW = $clog2(CLK_HZ);

    logic             sw_meta, sw_on;
    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] rem;
    logic             flash;
    state_t           state, state_next;
    logic             tick, half, expire, set_en, clr;

    assign tick   = pre == PW'(CLK_HZ - 1);
    assign half   = pre == PW'(CLK_HZ / 2 - 1);
    assign expire = tick && rem == CNT_W'(1);
    assign set_en = state != OFF && state != PED_GREEN;
    // Requests are served (or abandoned) on these entries, so the latches clear there.
    assign clr    = state_next != state && (state_next == PED_GREEN || state_next == OFF);

    assign remaining_s_out = rem;
    assign phase_out       = state;

    for (genvar i = 0; i < N_PED; i++) begin : g_req
        tl_req_latch u_req (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (ped_request_in[i]),
            .set_en (set_en),
            .clr    (clr),
            .pushed (pushed_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta <= 1'b0;
            sw_on   <= 1'b0;
            state   <= OFF;
        end else begin
            sw_meta <= switch_traffic_light_on_in;
            sw_on   <= sw_meta;
            state   <= state_next;
        end
    end

    // Switch-off is only honoured at the end of yellow, the end of ped-clear and in green,
    // so no pedestrian or car phase is ever cut short.
    always_comb begin
        car_red_light_out    = state inside {ALL_RED, PED_GREEN, PED_CLEAR, CAR_RED_YELLOW};
        car_yellow_light_out = state == CAR_YELLOW || state == CAR_RED_YELLOW || (state == OFF && !flash);
        car_green_light_out  = state == CAR_GREEN;
        ped_red_light_out    = state != OFF && state != PED_GREEN;
        ped_green_light_out  = state == PED_GREEN;
        state_next           = state;
        case (state)
            OFF:            state_next = sw_on ? PED_CLEAR : OFF;
            CAR_GREEN:      state_next = !sw_on || (|pushed_out && (rem == '0 || expire)) ? CAR_YELLOW : CAR_GREEN;
            CAR_YELLOW:     state_next = !expire ? CAR_YELLOW : sw_on ? ALL_RED : OFF;
            ALL_RED:        state_next = expire ? PED_GREEN : ALL_RED;
            PED_GREEN:      state_next = expire ? PED_CLEAR : PED_GREEN;
            PED_CLEAR:      state_next = !expire ? PED_CLEAR : sw_on ? CAR_RED_YELLOW : OFF;
            CAR_RED_YELLOW: state_next = expire ? CAR_GREEN : CAR_RED_YELLOW;
            default:        state_next = OFF;
        endcase
    end

    // In OFF the prescaler runs at half period to drive the yellow flash; elsewhere it
    // paces the seconds countdown, which saturates at 0 (used as min-green elapsed).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre   <= '0;
            rem   <= '0;
            flash <= 1'b0;
        end else if (state_next != state) begin
            pre   <= '0;
            rem   <= CNT_W'(phase_secs(state_next, T_GREEN_MIN, T_YELLOW, T_ALL_RED,
                                       T_PED_GREEN, T_PED_CLEAR, T_RED_YELLOW));
            flash <= 1'b0;
        end else if (state == OFF) begin
            pre   <= half ? '0 : pre + 1'b1;
            flash <= flash ^ half;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            rem <= tick && rem != '0 ? rem - 1'b1 : rem;
        end
    end

endmodule
